// File: rtl/dq_lsu_issue.sv
// dq_lsu_issue: issue stage for decoded DQ-form quadword loads/stores.
// Reads the base GPR (when RA != 0) and, for stxv, the source VSR, then
// presents one quadword memory request and waits for it to be accepted.
// Malformed lq encodings and the reserved opcode raise a one-cycle
// illegal_o pulse instead of issuing.
//
// Handshake rule, used on every interface of this block: a transfer
// happens on the rising edge where valid (or read enable) and the
// matching ready/valid response are both high. The requester holds its
// request and all payload fields stable until that edge.
module dq_lsu_issue #(
    parameter int regWidth  = 5,
    parameter int immWidth  = 12,
    parameter int addrWidth = 64,
    parameter int gprWidth  = 64,
    parameter int vsrWidth  = 128
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic [1:0]           opType_i,
    input  logic [regWidth-1:0]  reg1_i,
    input  logic [regWidth-1:0]  reg2_i,
    input  logic [immWidth-1:0]  imm_i,
    input  logic                 bit_i,
    output logic                 ready_o,
    output logic                 gprReadEn_o,
    output logic [regWidth-1:0]  gprReadAddr_o,
    input  logic [gprWidth-1:0]  gprReadData_i,
    input  logic                 gprReadValid_i,
    output logic                 vsrReadEn_o,
    output logic [5:0]           vsrReadAddr_o,
    input  logic [vsrWidth-1:0]  vsrReadData_i,
    input  logic                 vsrReadValid_i,
    output logic                 memValid_o,
    input  logic                 memReady_i,
    output logic [addrWidth-1:0] memAddr_o,
    output logic                 memIsStore_o,
    output logic [5:0]           memTarget_o,
    output logic [vsrWidth-1:0]  memData_o,
    output logic                 illegal_o,
    output logic [1:0]           stateDbg_o
);

    localparam logic [1:0] OP_LQ   = 2'd0;
    localparam logic [1:0] OP_LXV  = 2'd1;
    localparam logic [1:0] OP_STXV = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;
    localparam int         OFF_W   = immWidth + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BASE = 2'd1,
        RD_DATA = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           op_q;
    logic [regWidth-1:0]  reg1_q;
    logic [regWidth-1:0]  reg2_q;
    logic [immWidth-1:0]  imm_q;
    logic                 bit_q;
    logic [addrWidth-1:0] base_q;
    logic [vsrWidth-1:0]  data_q;
    logic                 illegal_q;

    logic                 accept;
    logic                 form_bad;
    logic [OFF_W-1:0]     off_raw;
    logic [addrWidth-1:0] offset;
    logic [addrWidth-1:0] ea;

    // An instruction is only taken while idle; enable_i elsewhere is ignored.
    assign accept   = (state_q == IDLE) && enable_i;
    // lq needs an even RTp that differs from RA; opcode 3 is never legal.
    assign form_bad = (opType_i == OP_RSVD) ||
                      ((opType_i == OP_LQ) && (reg1_i[0] || (reg1_i == reg2_i)));

    // DQ is a quadword-scaled displacement: shift by 4, sign-extend, add mod 2^addrWidth.
    assign off_raw = {imm_q, 4'b0000};
    assign offset  = {{(addrWidth - OFF_W){off_raw[OFF_W-1]}}, off_raw};
    assign ea      = base_q + offset;

    // State register.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RA==0 skips the base read, only stxv visits RD_DATA.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !form_bad) begin
                    if (reg2_i != '0)            state_d = RD_BASE;
                    else if (opType_i == OP_STXV) state_d = RD_DATA;
                    else                          state_d = ISSUE;
                end
            end
            RD_BASE: begin
                if (gprReadValid_i) state_d = (op_q == OP_STXV) ? RD_DATA : ISSUE;
            end
            RD_DATA: begin
                if (vsrReadValid_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (memReady_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction fields, base and store data; read data is taken only in its waiting state.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            op_q      <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            imm_q     <= '0;
            bit_q     <= 1'b0;
            base_q    <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && form_bad;
            if (accept && !form_bad) begin
                op_q   <= opType_i;
                reg1_q <= reg1_i;
                reg2_q <= reg2_i;
                imm_q  <= imm_i;
                bit_q  <= bit_i;
                base_q <= '0;
                data_q <= '0;
            end
            if ((state_q == RD_BASE) && gprReadValid_i) begin
                base_q <= addrWidth'(gprReadData_i);
            end
            if ((state_q == RD_DATA) && vsrReadValid_i) begin
                data_q <= vsrReadData_i;
            end
        end
    end

    // Outputs: pure function of state and latched fields, so they hold steady during stalls.
    always_comb begin
        ready_o       = 1'b0;
        gprReadEn_o   = 1'b0;
        gprReadAddr_o = '0;
        vsrReadEn_o   = 1'b0;
        vsrReadAddr_o = '0;
        memValid_o    = 1'b0;
        memAddr_o     = '0;
        memIsStore_o  = 1'b0;
        memTarget_o   = '0;
        memData_o     = '0;
        illegal_o     = illegal_q;
        stateDbg_o    = state_q;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            RD_BASE: begin
                gprReadEn_o   = 1'b1;
                gprReadAddr_o = reg2_q;
            end
            RD_DATA: begin
                vsrReadEn_o   = 1'b1;
                vsrReadAddr_o = 6'({bit_q, reg1_q});
            end
            ISSUE: begin
                memValid_o   = 1'b1;
                memAddr_o    = ea;
                memIsStore_o = (op_q == OP_STXV);
                case (op_q)
                    OP_LQ:   memTarget_o = 6'({1'b0, reg1_q});
                    OP_LXV:  memTarget_o = 6'({bit_q, reg1_q});
                    default: memTarget_o = '0;
                endcase
                if (op_q == OP_STXV) memData_o = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dq_lsu_issue.sv
// tb_dq_lsu_issue: directed cases plus randomized DQ load/store traffic
// against a register-file / memory-side model kept in this bench.
module tb_dq_lsu_issue;

    logic         clock_i;
    logic         reset_n_i;
    logic         enable_i;
    logic [1:0]   opType_i;
    logic [4:0]   reg1_i;
    logic [4:0]   reg2_i;
    logic [11:0]  imm_i;
    logic         bit_i;
    logic         ready_o;
    logic         gprReadEn_o;
    logic [4:0]   gprReadAddr_o;
    logic [63:0]  gprReadData_i;
    logic         gprReadValid_i;
    logic         vsrReadEn_o;
    logic [5:0]   vsrReadAddr_o;
    logic [127:0] vsrReadData_i;
    logic         vsrReadValid_i;
    logic         memValid_o;
    logic         memReady_i;
    logic [63:0]  memAddr_o;
    logic         memIsStore_o;
    logic [5:0]   memTarget_o;
    logic [127:0] memData_o;
    logic         illegal_o;
    logic [1:0]   stateDbg_o;

    // Register file contents seen by the DUT.
    logic [63:0]  gpr[32];
    logic [127:0] vsr[64];

    // Scoreboard of expected requests: {addr, is_store, target, data}.
    logic [198:0] exp_q[$];

    int chk_cnt = 0;
    int err_cnt = 0;

    dq_lsu_issue dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
        .opType_i(opType_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .imm_i(imm_i), .bit_i(bit_i),
        .ready_o(ready_o),
        .gprReadEn_o(gprReadEn_o), .gprReadAddr_o(gprReadAddr_o),
        .gprReadData_i(gprReadData_i), .gprReadValid_i(gprReadValid_i),
        .vsrReadEn_o(vsrReadEn_o), .vsrReadAddr_o(vsrReadAddr_o),
        .vsrReadData_i(vsrReadData_i), .vsrReadValid_i(vsrReadValid_i),
        .memValid_o(memValid_o), .memReady_i(memReady_i), .memAddr_o(memAddr_o),
        .memIsStore_o(memIsStore_o), .memTarget_o(memTarget_o), .memData_o(memData_o),
        .illegal_o(illegal_o), .stateDbg_o(stateDbg_o)
    );

    // Clock.
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Quiet state expected whenever the block is idle.
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, ready_o, 1);
        chk({tag, "_memv"}, memValid_o, 0);
        chk({tag, "_gpren"}, gprReadEn_o, 0);
        chk({tag, "_vsren"}, vsrReadEn_o, 0);
    endtask

    // mode 0: random waits/stalls, 1: zero-wait everything, 2: memReady low for 5 valid cycles.
    task automatic do_instr(input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [11:0] imm, input logic b, input int mode);
        logic         bad;
        logic [63:0]  base;
        longint       off;
        logic [63:0]  e_addr;
        logic         e_st;
        logic [5:0]   e_tg;
        logic [127:0] e_data;
        int           cyc;
        int           nvalid;
        int           exp_lat;
        bit           done;
        bit           saw_gpr;
        bit           saw_vsr;
        bit           go;

        bad = (op == 2'd3) || (op == 2'd0 && (r1[0] || r1 == r2));

        enable_i = 1'b1; opType_i = op; reg1_i = r1; reg2_i = r2; imm_i = imm; bit_i = b;
        @(negedge clock_i);
        enable_i = 1'b0;
        opType_i = 2'($urandom); reg1_i = 5'($urandom); reg2_i = 5'($urandom);

        if (bad) begin
            chk("ill_pulse", illegal_o, 1);
            chk_idle("ill_a");
            @(negedge clock_i);
            chk("ill_clear", illegal_o, 0);
            chk_idle("ill_b");
            return;
        end

        base   = (r2 == 5'd0) ? 64'd0 : gpr[r2];
        off    = longint'($signed({imm, 4'b0000}));
        e_addr = base + 64'(off);
        e_st   = (op == 2'd2);
        e_tg   = (op == 2'd0) ? {1'b0, r1} : (op == 2'd1) ? {b, r1} : 6'd0;
        e_data = (op == 2'd2) ? vsr[{b, r1}] : 128'd0;
        exp_q.push_back({e_addr, e_st, e_tg, e_data});
        exp_lat = 1 + ((r2 != 0) ? 1 : 0) + ((op == 2'd2) ? 1 : 0);

        cyc = 1; nvalid = 0; done = 0; saw_gpr = 0; saw_vsr = 0;
        while (!done && cyc < 100) begin
            chk("busy_ready", ready_o, 0);
            chk("busy_ill", illegal_o, 0);
            gprReadValid_i = 1'b0; vsrReadValid_i = 1'b0; memReady_i = 1'b0;
            gprReadData_i = rnd128()[63:0]; vsrReadData_i = rnd128();

            if (gprReadEn_o) begin
                saw_gpr = 1;
                chk("gpr_addr", gprReadAddr_o, r2);
                if (mode == 1 || $urandom_range(0, 2) == 0) begin
                    gprReadValid_i = 1'b1;
                    gprReadData_i  = gpr[gprReadAddr_o];
                end
            end else if (mode == 0 && $urandom_range(0, 3) == 0) begin
                gprReadValid_i = 1'b1;   // stray response, must be ignored
            end

            if (vsrReadEn_o) begin
                saw_vsr = 1;
                chk("vsr_addr", vsrReadAddr_o, {b, r1});
                if (mode == 1 || $urandom_range(0, 2) == 0) begin
                    vsrReadValid_i = 1'b1;
                    vsrReadData_i  = vsr[vsrReadAddr_o];
                end
            end else if (mode == 0 && $urandom_range(0, 3) == 0) begin
                vsrReadValid_i = 1'b1;   // stray response, must be ignored
            end

            if (memValid_o) begin
                nvalid++;
                if (nvalid == 1 && mode == 1) chk("latency", cyc, exp_lat);
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    {e_addr, e_st, e_tg, e_data} = exp_q[0];
                    chk("mem_addr", memAddr_o, e_addr);
                    chk("mem_st", memIsStore_o, e_st);
                    chk("mem_tgt", memTarget_o, e_tg);
                    chk("mem_data", memData_o, e_data);
                end
                go = (mode == 1) || (mode == 2 && nvalid == 6) ||
                     (mode == 0 && $urandom_range(0, 1) == 1);
                if (go) begin
                    memReady_i = 1'b1;
                    done = 1;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            @(negedge clock_i);
            cyc++;
        end
        gprReadValid_i = 1'b0; vsrReadValid_i = 1'b0; memReady_i = 1'b0;
        if (!done) begin
            chk("timeout", 0, 1);
            exp_q.delete();
        end
        chk_idle("post");
        chk("saw_gpr", saw_gpr, (r2 != 0));
        chk("saw_vsr", saw_vsr, (op == 2'd2));
        if (mode == 2) chk("stall_len", nvalid, 6);
    endtask

    // Stimulus and checking.
    initial begin
        int k;
        for (int i = 0; i < 32; i++) gpr[i] = rnd128()[63:0];
        for (int i = 0; i < 64; i++) vsr[i] = rnd128();
        reset_n_i = 1'b0; enable_i = 1'b0; opType_i = '0; reg1_i = '0; reg2_i = '0;
        imm_i = '0; bit_i = 1'b0; gprReadData_i = '0; gprReadValid_i = 1'b0;
        vsrReadData_i = '0; vsrReadValid_i = 1'b0; memReady_i = 1'b0;

        repeat (3) @(negedge clock_i);
        chk_idle("reset");
        chk("reset_ill", illegal_o, 0);
        chk("reset_addr", memAddr_o, 0);
        reset_n_i = 1'b1;
        @(negedge clock_i);

        // Directed cases.
        gpr[3] = 64'h1000;
        do_instr(2'd1, 5'd5, 5'd3, 12'h002, 1'b1, 1);
        vsr[7] = {16{8'hA5}};
        do_instr(2'd2, 5'd7, 5'd0, 12'hFFF, 1'b0, 1);
        gpr[2] = 64'hFFFF_FFFF_FFFF_FFF0;
        do_instr(2'd0, 5'd4, 5'd2, 12'h001, 1'b0, 1);
        do_instr(2'd0, 5'd3, 5'd1, 12'h010, 1'b0, 1);
        do_instr(2'd0, 5'd6, 5'd6, 12'h010, 1'b0, 1);
        do_instr(2'd3, 5'd8, 5'd1, 12'h010, 1'b0, 1);
        do_instr(2'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1);
        do_instr(2'd1, 5'd9, 5'd4, 12'h7FF, 1'b0, 2);

        // Reset while RD_DATA waits with a read response pending.
        gpr[1] = 64'h2000;
        enable_i = 1'b1; opType_i = 2'd2; reg1_i = 5'd9; reg2_i = 5'd1; imm_i = 12'h0; bit_i = 1'b1;
        @(negedge clock_i);
        enable_i = 1'b0;
        k = 0;
        while (!vsrReadEn_o && k < 20) begin
            gprReadValid_i = gprReadEn_o;
            gprReadData_i  = gpr[1];
            @(negedge clock_i);
            k++;
        end
        gprReadValid_i = 1'b0;
        chk("rst_reach_rddata", vsrReadEn_o, 1);
        vsrReadValid_i = 1'b1; vsrReadData_i = rnd128();
        reset_n_i = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_addr", memAddr_o, 0);
        chk("rst_mid_data", memData_o, 0);
        chk("rst_mid_vaddr", vsrReadAddr_o, 0);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        repeat (3) begin
            @(negedge clock_i);
            chk_idle("rst_after");
        end
        vsrReadValid_i = 1'b0;
        exp_q.delete();

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            logic [4:0] r1;
            k  = $urandom_range(0, 9);
            op = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
            r1 = 5'($urandom);
            if (op == 2'd0 && $urandom_range(0, 3) != 0) r1[0] = 1'b0;
            if ($urandom_range(0, 15) == 0) gpr[$urandom_range(1, 31)] = rnd128()[63:0];
            do_instr(op, r1, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                     12'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 3) == 0) @(negedge clock_i);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
